// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target endpoint.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_RX_DATA,
      ST_RX_ACK,
      ST_TX_DATA,
      ST_TX_ACK,
      ST_WAIT_STOP
   } i2c_tgt_state_t;

   localparam logic I2C_ACK     = 1'b0;
   localparam logic I2C_NACK    = 1'b1;
   localparam logic I2C_RW_READ = 1'b1;

   // Bits per byte minus one; bit_cnt counts down from here to 0.
   localparam logic [2:0] BIT_CNT_TOP = 3'd7;

   // Every register of the target datapath, updated together each clk.
   typedef struct packed {
      logic       sda_oe;
      logic       busy;
      logic       rw;
      logic [2:0] bit_cnt;
      logic [7:0] rx_shift;
      logic [7:0] tx_shift;
      logic [7:0] rx_data;
      logic       rx_valid;
      logic       tx_req;
   } i2c_tgt_regs_t;

endpackage

// File: rtl/i2c_target_if.sv
// Bus and byte-port signals of the I2C target, seen from target and host side.
interface i2c_target_if;

   logic       scl_i;
   logic       sda_i;
   logic       sda_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_req;
   logic [7:0] tx_data;
   logic       busy;
   logic       rw_o;

   modport slave (
      input  scl_i, sda_i, tx_data,
      output sda_oe, rx_data, rx_valid, tx_req, busy, rw_o
   );

   modport master (
      output scl_i, sda_i, tx_data,
      input  sda_oe, rx_data, rx_valid, tx_req, busy, rw_o
   );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizes raw SCL/SDA and derives SCL edges plus START/STOP conditions.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic resetN,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_s;
   logic                   scl_p;
   logic                   sda_p;

   // Synchronizer chains plus one previous sample of each line for edge detection.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         // NOTE: reset to the idle bus level (high) so releasing reset never looks like an edge.
         scl_sync <= '1;
         sda_sync <= '1;
         scl_p    <= 1'b1;
         sda_p    <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge value of its neighbour.
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
         scl_p    <= scl_sync[SYNC_STAGES-1];
         sda_p    <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  =  scl_s & ~scl_p;
   assign scl_fall  = ~scl_s &  scl_p;
   // SDA moving while SCL stays high marks a bus condition, never data.
   assign start_det =  scl_s & scl_p &  sda_p & ~sda_s;
   assign stop_det  =  scl_s & scl_p & ~sda_p &  sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: address match, write bytes out, read bytes in, open-drain SDA.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] TARGET_ADDR = 7'h50,
   parameter int         SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         resetN,
   i2c_target_if.slave  bus
);

   logic           scl_rise;
   logic           scl_fall;
   logic           start_det;
   logic           stop_det;
   logic           sda_s;
   logic [7:0]     byte_in;
   logic           addr_match;
   i2c_tgt_state_t state_q;
   i2c_tgt_state_t state_d;
   i2c_tgt_regs_t  q;
   i2c_tgt_regs_t  d;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .resetN    (resetN),
      .scl_i     (bus.scl_i),
      .sda_i     (bus.sda_i),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   // Byte as it will look once the bit sampled at this scl_rise is shifted in.
   assign byte_in    = {q.rx_shift[6:0], sda_s};
   assign addr_match = (byte_in[7:1] == TARGET_ADDR);

   // State register.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; STOP beats START, and both beat any SCL edge.
   always_comb begin
      // NOTE: default first so no path leaves state_d unassigned (no latch).
      state_d = state_q;
      if (stop_det) begin
         state_d = ST_IDLE;
      end else if (start_det) begin
         state_d = ST_ADDR;
      end else begin
         case (state_q)
            ST_ADDR:
               if (scl_rise && q.bit_cnt == 3'd0)
                  state_d = addr_match ? ST_ADDR_ACK : ST_WAIT_STOP;
            // sda_oe low on a fall means the ACK is not yet driven; high means it ends.
            ST_ADDR_ACK:
               if (scl_fall && q.sda_oe)
                  state_d = (q.rw == I2C_RW_READ) ? ST_TX_DATA : ST_RX_DATA;
            ST_RX_DATA:
               if (scl_rise && q.bit_cnt == 3'd0) state_d = ST_RX_ACK;
            ST_RX_ACK:
               if (scl_fall && q.sda_oe) state_d = ST_RX_DATA;
            ST_TX_DATA:
               if (scl_fall && q.bit_cnt == 3'd0) state_d = ST_TX_ACK;
            // A NACK leaves at the rise, so any fall seen here follows an ACK.
            ST_TX_ACK:
               if (scl_rise && sda_s == I2C_NACK) state_d = ST_WAIT_STOP;
               else if (scl_fall)                 state_d = ST_TX_DATA;
            default: ;
         endcase
      end
   end

   // Datapath and output next values for the current state and bus events.
   always_comb begin
      d          = q;
      d.rx_valid = 1'b0;
      d.tx_req   = 1'b0;
      if (stop_det) begin
         d.sda_oe  = 1'b0;
         d.busy    = 1'b0;
         d.bit_cnt = BIT_CNT_TOP;
      end else if (start_det) begin
         d.sda_oe  = 1'b0;
         d.bit_cnt = BIT_CNT_TOP;
      end else begin
         case (state_q)
            ST_ADDR:
               if (scl_rise) begin
                  d.rx_shift = byte_in;
                  d.bit_cnt  = q.bit_cnt - 3'd1;
                  if (q.bit_cnt == 3'd0) begin
                     d.bit_cnt = BIT_CNT_TOP;
                     if (addr_match) begin
                        d.rw   = byte_in[0];
                        d.busy = 1'b1;
                     end
                  end
               end
            ST_ADDR_ACK, ST_RX_ACK:
               if (scl_fall) begin
                  if (!q.sda_oe) begin
                     d.sda_oe = 1'b1;
                  end else if (state_q == ST_ADDR_ACK && q.rw == I2C_RW_READ) begin
                     // Hold SDA until the first read bit is loaded one clk after tx_req.
                     d.tx_req = 1'b1;
                  end else begin
                     d.sda_oe = 1'b0;
                  end
               end
            ST_RX_DATA:
               if (scl_rise) begin
                  d.rx_shift = byte_in;
                  d.bit_cnt  = q.bit_cnt - 3'd1;
                  if (q.bit_cnt == 3'd0) begin
                     d.bit_cnt  = BIT_CNT_TOP;
                     d.rx_data  = byte_in;
                     d.rx_valid = 1'b1;
                  end
               end
            ST_TX_DATA:
               if (q.tx_req) begin
                  d.tx_shift = bus.tx_data;
                  d.sda_oe   = ~bus.tx_data[7];
               end else if (scl_fall) begin
                  if (q.bit_cnt == 3'd0) begin
                     d.sda_oe  = 1'b0;
                     d.bit_cnt = BIT_CNT_TOP;
                  end else begin
                     d.tx_shift = {q.tx_shift[6:0], 1'b0};
                     d.sda_oe   = ~q.tx_shift[6];
                     d.bit_cnt  = q.bit_cnt - 3'd1;
                  end
               end
            ST_TX_ACK:
               if (scl_rise && sda_s == I2C_NACK) begin
                  d.busy = 1'b0;
               end else if (scl_fall) begin
                  d.tx_req  = 1'b1;
                  d.bit_cnt = BIT_CNT_TOP;
               end
            ST_WAIT_STOP:
               d.sda_oe = 1'b0;
            default: ;
         endcase
      end
   end

   // Datapath register; the asynchronous reset releases SDA immediately.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) q <= '0;
      else         q <= d;
   end

   assign bus.sda_oe   = q.sda_oe;
   assign bus.rx_data  = q.rx_data;
   assign bus.rx_valid = q.rx_valid;
   assign bus.tx_req   = q.tx_req;
   assign bus.busy     = q.busy;
   assign bus.rw_o     = q.rw;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: bit-level bus master plus transaction-level model.
module tb_i2c_target;
   import i2c_pkg::*;

   localparam logic [6:0] MODEL_ADDR = 7'h50;
   localparam int         Q          = 4;   // clks per quarter SCL period

   logic clk = 1'b0;
   logic resetN;
   logic scl_m;
   logic sda_m;
   logic [7:0] tx_data_r = '0;

   int errors = 0;
   int checks = 0;
   int tx_req_cnt = 0;
   int oe_cycles = 0;
   logic [7:0] rx_log [$];
   logic [7:0] tx_q [$];

   i2c_target_if bus ();

   // Open-drain bus: master and target can only pull the line low.
   assign bus.scl_i   = scl_m;
   assign bus.sda_i   = sda_m & ~bus.sda_oe;
   assign bus.tx_data = tx_data_r;

   i2c_target #(.TARGET_ADDR(7'h50), .SYNC_STAGES(2)) dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Host-side monitor: logs received bytes, answers tx_req, counts SDA pull cycles.
   always @(negedge clk) begin
      if (bus.rx_valid) rx_log.push_back(bus.rx_data);
      if (bus.tx_req) begin
         tx_req_cnt++;
         if (tx_q.size() != 0) tx_data_r = tx_q.pop_front();
      end
      if (bus.sda_oe) oe_cycles++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_q();
      repeat (Q) @(posedge clk);
      #1;
   endtask

   // START from idle, or repeated START when SCL is low.
   task automatic send_start();
      sda_m = 1'b1; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b0; wait_q();
   endtask

   task automatic send_stop();
      sda_m = 1'b0; wait_q();
      scl_m = 1'b1; wait_q();
      sda_m = 1'b1; wait_q();
   endtask

   // One SCL clock: drive b while low, sample the wired bus mid-high.
   task automatic xfer_bit(input logic b, output logic seen);
      sda_m = b; wait_q();
      scl_m = 1'b1;
      repeat (2) @(posedge clk);
      #3 seen = bus.sda_i;
      repeat (Q - 2) @(posedge clk);
      #1 scl_m = 1'b0;
      wait_q();
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) xfer_bit(b[i], s);
      xfer_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         xfer_bit(1'b1, s);
         b[i] = s;
      end
      xfer_bit(mack, s);
   endtask

   // One transaction with expectations from the transaction-level rules:
   // a matching address ACKs and logs writes / serves reads, anything else is ignored.
   task automatic run_txn(input string tag, input logic [6:0] addr, input logic rw, input int n,
                          input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                          input logic end_stop);
      logic [7:0] d [3];
      logic       match;
      logic       ack;
      logic [7:0] got;
      int         rx0;
      int         tq0;
      d[0] = d0; d[1] = d1; d[2] = d2;
      match = (addr == MODEL_ADDR);
      rx0 = rx_log.size();
      tq0 = tx_req_cnt;
      if (match && rw) for (int i = 0; i < n; i++) tx_q.push_back(d[i]);
      send_start();
      write_byte({addr, rw}, ack);
      check({tag, ".addr_ack"}, ack, match ? 0 : 1);
      for (int i = 0; i < n; i++) begin
         if (rw) begin
            read_byte(i == n - 1, got);
            check({tag, ".rd_byte"}, got, match ? d[i] : 8'hFF);
         end else begin
            write_byte(d[i], ack);
            check({tag, ".wr_ack"}, ack, match ? 0 : 1);
         end
      end
      check({tag, ".rx_count"}, rx_log.size() - rx0, (match && !rw) ? n : 0);
      check({tag, ".tx_req_count"}, tx_req_cnt - tq0, (match && rw) ? n : 0);
      if (match && !rw)
         for (int i = 0; i < n; i++)
            if (rx0 + i < rx_log.size()) check({tag, ".rx_byte"}, rx_log[rx0 + i], d[i]);
      check({tag, ".busy"}, bus.busy, (match && !rw) ? 1 : 0);
      if (match) check({tag, ".rw_o"}, bus.rw_o, rw);
      if (end_stop) begin
         send_stop();
         wait_q();
         check({tag, ".busy_after_stop"}, bus.busy, 0);
         check({tag, ".idle_after_stop"}, dut.state_q, ST_IDLE);
      end
   endtask

   initial begin
      logic       s;
      logic       ack;
      logic [6:0] raddr;
      int         rx0;
      int         tq0;
      int         oe0;

      resetN = 1'b0;
      scl_m  = 1'b1;
      sda_m  = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("rst.sda_oe",   bus.sda_oe,   0);
      check("rst.rx_valid", bus.rx_valid, 0);
      check("rst.tx_req",   bus.tx_req,   0);
      check("rst.busy",     bus.busy,     0);
      check("rst.rw_o",     bus.rw_o,     0);
      check("rst.rx_data",  bus.rx_data,  0);
      check("rst.state",    dut.state_q,  ST_IDLE);
      resetN = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Write 0x3C, 0xC3 to our address.
      run_txn("wr2", 7'h50, 1'b0, 2, 8'h3C, 8'hC3, 8'h00, 1'b1);

      // Foreign address: no ACK, SDA never pulled, parked until STOP.
      oe0 = oe_cycles;
      run_txn("nomatch", 7'h51, 1'b0, 1, 8'($urandom), 8'h00, 8'h00, 1'b0);
      check("nomatch.oe_cycles", oe_cycles - oe0, 0);
      check("nomatch.wait_stop", dut.state_q, ST_WAIT_STOP);
      send_stop();
      wait_q();
      check("nomatch.idle", dut.state_q, ST_IDLE);

      // Read two bytes, master ACK then NACK.
      run_txn("rd2", 7'h50, 1'b1, 2, 8'h5A, 8'h81, 8'h00, 1'b1);

      // Write then repeated START into a one-byte read.
      run_txn("rs_wr", 7'h50, 1'b0, 1, 8'h11, 8'h00, 8'h00, 1'b0);
      run_txn("rs_rd", 7'h50, 1'b1, 1, 8'($urandom), 8'h00, 8'h00, 1'b1);

      // Reset while the target is pulling SDA during a read byte.
      tx_q.push_back(8'($urandom) & 8'h7F);
      send_start();
      write_byte({7'h50, 1'b1}, ack);
      check("rst_mid.addr_ack", ack, 0);
      for (int i = 0; i < 20 && !bus.sda_oe; i++) @(negedge clk);
      check("rst_mid.oe_before", bus.sda_oe, 1);
      #2 resetN = 1'b0;
      #1;
      check("rst_mid.oe_released", bus.sda_oe, 0);
      check("rst_mid.state", dut.state_q, ST_IDLE);
      repeat (2) @(posedge clk);
      #1 resetN = 1'b1;
      oe0 = oe_cycles;
      tq0 = tx_req_cnt;
      rx0 = rx_log.size();
      for (int i = 0; i < 8; i++) xfer_bit(1'b1, s);
      xfer_bit(1'b0, s);
      check("rst_mid.silent_oe", oe_cycles - oe0, 0);
      check("rst_mid.silent_tx_req", tx_req_cnt - tq0, 0);
      check("rst_mid.silent_rx", rx_log.size() - rx0, 0);
      send_stop();
      wait_q();
      run_txn("post_rst", 7'h50, 1'b0, 2, 8'($urandom), 8'($urandom), 8'h00, 1'b1);

      // STOP in the middle of a write data byte.
      rx0 = rx_log.size();
      send_start();
      write_byte({7'h50, 1'b0}, ack);
      check("midstop.addr_ack", ack, 0);
      for (int i = 0; i < 4; i++) xfer_bit(1'($urandom), s);
      send_stop();
      wait_q();
      check("midstop.rx_count", rx_log.size() - rx0, 0);
      check("midstop.busy", bus.busy, 0);
      check("midstop.state", dut.state_q, ST_IDLE);

      // Random transactions against the transaction-level model.
      for (int k = 0; k < 6; k++) begin
         raddr = ($urandom_range(0, 2) != 0) ? 7'h50 : 7'($urandom_range(0, 127));
         run_txn("rand", raddr, 1'($urandom), $urandom_range(1, 3),
                 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
